// File: rtl/part4_capture_pkg.sv
// rtl/part4_capture_pkg.sv - shared types, constants and MISR step function for the Part4 capture stage
package part4_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } captureStateT;

    localparam logic [15:0] DEFAULT_POLY   = 16'h1021;
    localparam int          MISR_MAX_WIDTH = 64;

    // Operates on a 64-bit container so any MISR width up to 64 can share it.
    function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                              input logic [63:0] din,
                                              input logic [63:0] poly,
                                              input int          width);
        logic [63:0] mask;
        logic        msb;
        mask = (width >= MISR_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        msb  = sig[width-1];
        return ({sig[62:0], 1'b0} ^ (msb ? poly : 64'd0) ^ din) & mask;
    endfunction

endpackage

// File: rtl/part4_misr_capture_if.sv
// rtl/part4_misr_capture_if.sv - capture control/observation bundle between Part4 side and the MISR stage
interface part4_capture_if #(
    parameter int BUS_WIDTH = 5,
    parameter int SIG_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic [BUS_WIDTH-1:0]           obsBus;
    logic                           start;
    logic [CNT_WIDTH-1:0]           windowLen;
    logic [SIG_WIDTH-1:0]           seed;
    logic                           busy;
    logic                           done;
    logic                           sigValid;
    logic [SIG_WIDTH-1:0]           signature;
    logic [BUS_WIDTH*CNT_WIDTH-1:0] toggleCnt;

    modport master (
        output obsBus, start, windowLen, seed,
        input  busy, done, sigValid, signature, toggleCnt
    );

    modport slave (
        input  obsBus, start, windowLen, seed,
        output busy, done, sigValid, signature, toggleCnt
    );
endinterface

// File: rtl/part4_misr_capture_toggle.sv
// rtl/part4_misr_capture_toggle.sv - single-bit saturating toggle counter (module toggle_counter)
module toggle_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 cur,
    input  logic                 prev,
    output logic [CNT_WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (cur != prev) && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/part4_misr_capture.sv
// rtl/part4_misr_capture.sv - windowed MISR capture of Part4 outBus; PART4_TOGGLE_CNT_EN adds per-bit toggle counters
module part4_misr_capture
    import part4_capture_pkg::*;
#(
    parameter int                   BUS_WIDTH = 5,
    parameter int                   SIG_WIDTH = 16,
    parameter int                   CNT_WIDTH = 8,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY)
) (
    input logic            clk,
    input logic            resetN,
    part4_capture_if.slave bus
);
    captureStateT         state, stateNext;
    logic [CNT_WIDTH-1:0] len;
    logic [CNT_WIDTH-1:0] sampleCnt;
    logic [CNT_WIDTH-1:0] lastIdx;
    logic [SIG_WIDTH-1:0] signature;
    logic [SIG_WIDTH-1:0] misrNext;
    logic                 busyQ;
    logic                 doneQ;
    logic                 sigValidQ;
    logic                 accept;

    assign accept   = (state == IDLE) && bus.start;
    assign lastIdx  = len - CNT_WIDTH'(1);
    assign misrNext = SIG_WIDTH'(misr_next(64'(signature), 64'(bus.obsBus), 64'(POLY), SIG_WIDTH));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (bus.start) stateNext = (bus.windowLen != '0) ? RUN : DONE;
            RUN:  if (sampleCnt == lastIdx) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // busy/done are registered copies of the state, so they trail it by one edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            len       <= '0;
            sampleCnt <= '0;
            signature <= '0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            sigValidQ <= 1'b0;
        end else begin
            state <= stateNext;
            busyQ <= (state != IDLE);
            doneQ <= (state == DONE);
            if (accept) begin
                len       <= bus.windowLen;
                signature <= bus.seed;
                sampleCnt <= '0;
                sigValidQ <= 1'b0;
            end else if (state == RUN) begin
                signature <= misrNext;
                sampleCnt <= sampleCnt + CNT_WIDTH'(1);
            end else if (state == DONE) begin
                sigValidQ <= 1'b1;
            end
        end
    end

    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.sigValid  = sigValidQ;
    assign bus.signature = signature;

`ifdef PART4_TOGGLE_CNT_EN
    logic [BUS_WIDTH-1:0] prevBus;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prevBus <= '0;
        end else if (accept || (state == RUN)) begin
            prevBus <= bus.obsBus;
        end
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_toggle
        toggle_counter #(.CNT_WIDTH(CNT_WIDTH)) u_toggle (
            .clk    (clk),
            .resetN (resetN),
            .clear  (accept),
            .enable (state == RUN),
            .cur    (bus.obsBus[i]),
            .prev   (prevBus[i]),
            .count  (bus.toggleCnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end
`else
    assign bus.toggleCnt = '0;
`endif

endmodule

// File: tb/tb_part4_misr_capture.sv
// tb/tb_part4_misr_capture.sv - randomized self-checking bench for part4_misr_capture
module tb_part4_misr_capture;
    localparam int BW = 5;
    localparam int SW = 16;
    localparam int CW = 8;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    part4_capture_if #(.BUS_WIDTH(BW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    part4_misr_capture #(.BUS_WIDTH(BW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    logic        expBusy, expDone, expValid;
    logic [15:0] expSig;
    int          expTog[BW];
    int          samples[$];
    int          firstObs = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x, reduce mod x^16+x^12+x^5+1, add the sample.
    function automatic logic [15:0] model_sig(input logic [15:0] s, input logic [4:0] o);
        int v;
        v = int'(s) << 1;
        if ((v & 'h10000) != 0) v = v ^ 'h11021;
        v = v ^ int'(o);
        return 16'(v);
    endfunction

    function automatic logic [39:0] model_tog();
        logic [39:0] r;
        r = '0;
`ifdef PART4_TOGGLE_CNT_EN
        for (int i = 0; i < BW; i++) r[i*CW +: CW] = 8'(expTog[i]);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("busy",      64'(bus.busy),      64'(expBusy));
            check("done",      64'(bus.done),      64'(expDone));
            check("sigValid",  64'(bus.sigValid),  64'(expValid));
            check("signature", 64'(bus.signature), 64'(expSig));
            check("toggleCnt", 64'(bus.toggleCnt), 64'(model_tog()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [15:0] seedV, input int n, input bit inject, input int firstPin);
        logic [4:0] prev, obs;
        prev = (firstObs >= 0) ? 5'(firstObs) : 5'($urandom);
        bus.start     = 1'b1;
        bus.windowLen = 8'(n);
        bus.seed      = seedV;
        bus.obsBus    = prev;
        step();
        expSig = seedV; expValid = 1'b0; expBusy = 1'b0; expDone = 1'b0;
        for (int i = 0; i < BW; i++) expTog[i] = 0;
        bus.windowLen = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            obs        = (k < samples.size()) ? 5'(samples[k]) : 5'($urandom);
            bus.obsBus = obs;
            bus.start  = inject ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.seed   = inject ? 16'hFFFF : 16'($urandom);
            step();
            expSig  = model_sig(expSig, obs);
            expBusy = 1'b1;
            for (int i = 0; i < BW; i++)
                if (obs[i] != prev[i] && expTog[i] < 255) expTog[i]++;
            prev = obs;
            if (k == 0 && firstPin >= 0) check("first_sample", 64'(bus.signature), 64'(firstPin));
        end
        bus.obsBus = 5'($urandom);
        bus.start  = 1'($urandom);
        bus.seed   = 16'($urandom);
        step();
        expBusy = 1'b1; expDone = 1'b1; expValid = 1'b1;
        bus.start  = 1'b0;
        step();
        expBusy = 1'b0; expDone = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.windowLen = '0; bus.seed = '0; bus.obsBus = '0;
        expBusy = 1'b0; expDone = 1'b0; expValid = 1'b0; expSig = '0;
        for (int i = 0; i < BW; i++) expTog[i] = 0;
        repeat (2) step();
        check("rst_busy",  64'(bus.busy),      64'h0);
        check("rst_done",  64'(bus.done),      64'h0);
        check("rst_valid", 64'(bus.sigValid),  64'h0);
        check("rst_sig",   64'(bus.signature), 64'h0);
        check("rst_tog",   64'(bus.toggleCnt), 64'h0);
        check("model_pin_shift", 64'(model_sig(model_sig(16'h0000, 5'h01), 5'h01)), 64'h0003);
        check("model_pin_fb",    64'(model_sig(16'h8000, 5'h00)), 64'h1021);
        resetN  = 1'b1;
        checkEn = 1'b1;
        step();

        samples = '{1, 1};
        run_window(16'h0000, 2, 1'b0, 16'h0001);
        check("basic_sig",   64'(bus.signature), 64'h0003);
        check("basic_valid", 64'(bus.sigValid),  64'h1);

        samples = '{0};
        run_window(16'h8000, 1, 1'b0, -1);
        check("feedback_sig", 64'(bus.signature), 64'h1021);

        samples = {};
        run_window(16'hBEEF, 0, 1'b0, -1);
        check("zero_sig", 64'(bus.signature), 64'hBEEF);

        run_window(16'h1234, 4, 1'b1, -1);

        samples  = '{1, 0, 1, 0};
        firstObs = 0;
        run_window(16'h5A5A, 4, 1'b0, -1);
`ifdef PART4_TOGGLE_CNT_EN
        check("tog_bit0", 64'(bus.toggleCnt[7:0]), 64'd4);
`else
        check("tog_bit0", 64'(bus.toggleCnt[7:0]), 64'd0);
`endif
        check("tog_others", 64'(bus.toggleCnt[39:8]), 64'd0);
        firstObs = -1;
        samples  = {};

        // Asynchronous reset between edges in the middle of a window.
        checkEn = 1'b0;
        bus.start = 1'b1; bus.windowLen = 8'd10; bus.seed = 16'hA5A5; bus.obsBus = 5'h1F;
        step();
        bus.start = 1'b0;
        repeat (4) begin
            bus.obsBus = 5'($urandom);
            step();
        end
        #2 resetN = 1'b0;
        #1;
        check("arst_busy",  64'(bus.busy),      64'h0);
        check("arst_done",  64'(bus.done),      64'h0);
        check("arst_valid", 64'(bus.sigValid),  64'h0);
        check("arst_sig",   64'(bus.signature), 64'h0);
        check("arst_tog",   64'(bus.toggleCnt), 64'h0);
        expBusy = 1'b0; expDone = 1'b0; expValid = 1'b0; expSig = '0;
        for (int i = 0; i < BW; i++) expTog[i] = 0;
        checkEn = 1'b1;
        step();
        resetN = 1'b1;
        step();
        run_window(16'($urandom), 3, 1'b0, -1);

        for (int w = 0; w < 40; w++) begin
            repeat ($urandom_range(0, 3)) begin
                bus.obsBus = 5'($urandom);
                step();
            end
            run_window(16'($urandom), $urandom_range(0, 20), 1'($urandom), -1);
        end

        samples = {};
        for (int k = 0; k < 255; k++) samples.push_back((k % 2 == 0) ? 1 : 0);
        firstObs = 0;
        run_window(16'hFFFF, 255, 1'b0, -1);
`ifdef PART4_TOGGLE_CNT_EN
        check("max_tog_bit0", 64'(bus.toggleCnt[7:0]), 64'd255);
`endif
        firstObs = -1;
        samples  = {};

        step();
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
